mult_fu_cdb_tx: RTL and testbench

- Pipelined 64-bit integer multiply functional unit plus its result-broadcast transmitter toward the common data bus.
- Accepts issued multiplies and produces the low 64 bits of the product.
- Presents one completed result per FU slot (done, T_idx, ROB_idx, dest_idx, result) and holds it until the CDB slot is free.
- Squashes in-flight work younger than a rolled-back ROB index.

---
 rtl/mult_fu_cdb_tx.sv | 150 +++++++++++++++
 tb/tb_mult_fu_cdb_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_fu_cdb_tx.sv
// Pipelined 64-bit integer multiply unit (low half of the product) with a
// result-holding CDB transmitter and ROB-relative squash of younger work.
module mult_fu_cdb_tx #(
    parameter int NUM_ROB = 32,
    parameter int NUM_PR  = 64,
    parameter int STAGES  = 4,
    localparam int ROB_W  = $clog2(NUM_ROB),
    localparam int PR_W   = $clog2(NUM_PR)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             issue_valid,
    input  logic [63:0]      issue_opa,
    input  logic [63:0]      issue_opb,
    input  logic [PR_W-1:0]  issue_T_idx,
    input  logic [ROB_W-1:0] issue_ROB_idx,
    input  logic [4:0]       issue_dest_idx,
    output logic             ready,
    input  logic             rollback_en,
    input  logic [ROB_W-1:0] ROB_rollback_idx,
    input  logic [ROB_W-1:0] diff_ROB,
    input  logic             CDB_valid,
    output logic             done,
    output logic [PR_W-1:0]  T_idx,
    output logic [ROB_W-1:0] ROB_idx,
    output logic [4:0]       dest_idx,
    output logic [63:0]      result
);

    localparam int DATA_W = 64;
    localparam int CW     = DATA_W / STAGES;
    localparam int LAST   = STAGES - 1;
    localparam logic [DATA_W-1:0] CHUNK_MASK = {DATA_W{1'b1}} >> (DATA_W - CW);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [PR_W-1:0]   tidx_q   [STAGES];
    logic [PR_W-1:0]   tidx_d   [STAGES];
    logic [ROB_W-1:0]  rob_q    [STAGES];
    logic [ROB_W-1:0]  rob_d    [STAGES];
    logic [4:0]        dest_q   [STAGES];
    logic [4:0]        dest_d   [STAGES];
    logic [DATA_W-1:0] mcand_q  [STAGES];
    logic [DATA_W-1:0] mcand_d  [STAGES];
    logic [DATA_W-1:0] mplier_q [STAGES];
    logic [DATA_W-1:0] mplier_d [STAGES];
    logic [DATA_W-1:0] pp_q     [STAGES];
    logic [DATA_W-1:0] pp_d     [STAGES];

    logic [STAGES-1:0] kill, adv;
    logic              issue_kill;

    // Distance is taken modulo the ROB size so wrapped indices compare correctly.
    function automatic logic squash(input logic [ROB_W-1:0] rob,
                                    input logic [ROB_W-1:0] rb_idx,
                                    input logic [ROB_W-1:0] diff,
                                    input logic             rb_en);
        logic [ROB_W-1:0] d;
        d = rob - rb_idx;
        return rb_en && (d != '0) && (d <= diff);
    endfunction

    function automatic logic [DATA_W-1:0] chunk_mac(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] mcand,
                                                    input logic [DATA_W-1:0] mplier);
        return acc + mcand * (mplier & CHUNK_MASK);
    endfunction

    always_comb begin
        issue_kill = squash(issue_ROB_idx, ROB_rollback_idx, diff_ROB, rollback_en);
        for (int k = 0; k < STAGES; k++) begin
            kill[k] = squash(rob_q[k], ROB_rollback_idx, diff_ROB, rollback_en);
        end
        adv[LAST] = !valid_q[LAST] || CDB_valid;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = !valid_q[k+1] || adv[k+1];
        end
    end

    assign ready = en && adv[0];

    always_comb begin
        valid_d  = valid_q;
        tidx_d   = tidx_q;
        rob_d    = rob_q;
        dest_d   = dest_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        pp_d     = pp_q;
        if (en) begin
            if (adv[0]) begin
                valid_d[0]  = issue_valid && !issue_kill;
                tidx_d[0]   = issue_T_idx;
                rob_d[0]    = issue_ROB_idx;
                dest_d[0]   = issue_dest_idx;
                mcand_d[0]  = issue_opa << CW;
                mplier_d[0] = issue_opb >> CW;
                pp_d[0]     = chunk_mac('0, issue_opa, issue_opb);
            end else begin
                valid_d[0]  = valid_q[0] && !kill[0];
            end
            // Each later stage folds in the next multiplier chunk as it advances.
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid_d[k]  = valid_q[k-1] && !kill[k-1];
                    tidx_d[k]   = tidx_q[k-1];
                    rob_d[k]    = rob_q[k-1];
                    dest_d[k]   = dest_q[k-1];
                    mcand_d[k]  = mcand_q[k-1] << CW;
                    mplier_d[k] = mplier_q[k-1] >> CW;
                    pp_d[k]     = chunk_mac(pp_q[k-1], mcand_q[k-1], mplier_q[k-1]);
                end else begin
                    valid_d[k]  = valid_q[k] && !kill[k];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tidx_q[k]   <= '0;
                rob_q[k]    <= '0;
                dest_q[k]   <= '0;
                mcand_q[k]  <= '0;
                mplier_q[k] <= '0;
                pp_q[k]     <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                tidx_q[k]   <= tidx_d[k];
                rob_q[k]    <= rob_d[k];
                dest_q[k]   <= dest_d[k];
                mcand_q[k]  <= mcand_d[k];
                mplier_q[k] <= mplier_d[k];
                pp_q[k]     <= pp_d[k];
            end
        end
    end

    // A squashed last stage is hidden in the same cycle so the CDB never latches it.
    assign done     = valid_q[LAST] && !kill[LAST];
    assign T_idx    = done ? tidx_q[LAST] : '0;
    assign ROB_idx  = done ? rob_q[LAST]  : '0;
    assign dest_idx = done ? dest_q[LAST] : '0;
    assign result   = done ? pp_q[LAST]   : '0;

endmodule

// File: tb/tb_mult_fu_cdb_tx.sv
// Scoreboard bench for mult_fu_cdb_tx: directed issues push hand-computed
// results; a negedge monitor pops and compares on every CDB transfer.
module tb_mult_fu_cdb_tx;

    localparam int NUM_ROB = 32;
    localparam int NUM_PR  = 64;
    localparam int STAGES  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic        issue_valid;
    logic [63:0] issue_opa, issue_opb;
    logic [5:0]  issue_T_idx;
    logic [4:0]  issue_ROB_idx;
    logic [4:0]  issue_dest_idx;
    logic        ready;
    logic        rollback_en;
    logic [4:0]  ROB_rollback_idx;
    logic [4:0]  diff_ROB;
    logic        CDB_valid;
    logic        done;
    logic [5:0]  T_idx;
    logic [4:0]  ROB_idx;
    logic [4:0]  dest_idx;
    logic [63:0] result;

    typedef struct packed {
        logic [5:0]  t;
        logic [4:0]  r;
        logic [4:0]  d;
        logic [63:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    mult_fu_cdb_tx #(.NUM_ROB(NUM_ROB), .NUM_PR(NUM_PR), .STAGES(STAGES)) dut (
        .clock(clock), .reset(reset), .en(en),
        .issue_valid(issue_valid), .issue_opa(issue_opa), .issue_opb(issue_opb),
        .issue_T_idx(issue_T_idx), .issue_ROB_idx(issue_ROB_idx),
        .issue_dest_idx(issue_dest_idx), .ready(ready),
        .rollback_en(rollback_en), .ROB_rollback_idx(ROB_rollback_idx),
        .diff_ROB(diff_ROB), .CDB_valid(CDB_valid),
        .done(done), .T_idx(T_idx), .ROB_idx(ROB_idx),
        .dest_idx(dest_idx), .result(result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when en, done and CDB_valid are high.
    always @(negedge clock) begin
        if (reset === 1'b1 && en && done && CDB_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL cdb_unexpected: got rob %0d res %0h want none", ROB_idx, result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cdb_T_idx",    64'(T_idx),    64'(e.t));
                chk("cdb_ROB_idx",  64'(ROB_idx),  64'(e.r));
                chk("cdb_dest_idx", 64'(dest_idx), 64'(e.d));
                chk("cdb_result",   result,        e.res);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_issue(input logic [63:0] a, input logic [63:0] b, input logic [63:0] res,
                            input logic [5:0] t, input logic [4:0] r, input logic [4:0] d,
                            input bit push);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        issue_opa = a; issue_opb = b; issue_T_idx = t;
        issue_ROB_idx = r; issue_dest_idx = d; issue_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (ready) begin
                ok = 1'b1;
                if (push) begin
                    e.t = t; e.r = r; e.d = d; e.res = res;
                    exp_q.push_back(e);
                end
            end
            @(posedge clock);
            #1;
        end
        issue_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: rob %0d not accepted want accepted", r);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        step();
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_done_low", 64'(done), 64'd0);
    endtask

    int ones;
    bit last0;

    initial begin
        reset = 1'b0; en = 1'b1; issue_valid = 1'b0;
        issue_opa = '0; issue_opb = '0; issue_T_idx = '0; issue_ROB_idx = '0; issue_dest_idx = '0;
        rollback_en = 1'b0; ROB_rollback_idx = '0; diff_ROB = '0; CDB_valid = 1'b1;
        step(); step();
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_T_idx", 64'(T_idx), 64'd0);
        reset = 1'b1;
        #1;
        chk("reset_ready", 64'(ready), 64'd1);
        step();

        // Latency: 3*5 appears exactly four cycles after the issue is driven.
        do_issue(64'd3, 64'd5, 64'd15, 6'd7, 5'd2, 5'd4, 1'b1);
        chk("lat_c1_done", 64'(done), 64'd0);
        step();
        chk("lat_c2_done", 64'(done), 64'd0);
        step();
        chk("lat_c3_done", 64'(done), 64'd0);
        step();
        chk("lat_c4_done", 64'(done), 64'd1);
        chk("lat_c4_result", result, 64'd15);
        chk("lat_c4_T_idx", 64'(T_idx), 64'd7);
        chk("lat_c4_ROB_idx", 64'(ROB_idx), 64'd2);
        chk("lat_c4_dest", 64'(dest_idx), 64'd4);
        step();
        chk("lat_c5_done", 64'(done), 64'd0);

        // Wrap, then four back-to-back issues.
        do_issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 6'd1, 5'd3, 5'd1, 1'b1);
        wait_drain();
        do_issue(64'd7, 64'd6, 64'd42, 6'd10, 5'd4, 5'd2, 1'b1);
        do_issue(64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 6'd11, 5'd5, 5'd3, 1'b1);
        do_issue(64'h1234, 64'h10, 64'h12340, 6'd12, 5'd6, 5'd5, 1'b1);
        do_issue(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 6'd13, 5'd7, 5'd6, 1'b1);
        ones = 0; last0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i < 4 && done) ones++;
            if (i == 4) last0 = !done;
        end
        chk("b2b_consecutive_done", 64'(ones), 64'd4);
        chk("b2b_then_idle", 64'(last0), 64'd1);
        #1;
        wait_drain();

        // Backpressure: CDB busy, pipe fills to four, fifth op waits.
        CDB_valid = 1'b0;
        do_issue(64'd2, 64'd3, 64'd6, 6'd20, 5'd8, 5'd7, 1'b1);
        do_issue(64'd100, 64'd100, 64'd10000, 6'd21, 5'd9, 5'd8, 1'b1);
        do_issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd22, 5'd10, 5'd9, 1'b1);
        do_issue(64'd0, 64'd12345, 64'd0, 6'd23, 5'd11, 5'd10, 1'b1);
        issue_opa = 64'h8000_0000_0000_0000; issue_opb = 64'd3; issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_low", 64'(ready), 64'd0);
            chk("bp_done_held", 64'(done), 64'd1);
            chk("bp_result_held", result, 64'd6);
            chk("bp_T_idx_held", 64'(T_idx), 64'd20);
            step();
        end
        CDB_valid = 1'b1;
        do_issue(64'h8000_0000_0000_0000, 64'd3, 64'h8000_0000_0000_0000, 6'd24, 5'd12, 5'd11, 1'b1);
        wait_drain();

        // Rollback: ROB 0 and 1 are younger than 31 within diff 3 and get squashed.
        do_issue(64'd11, 64'd11, 64'd121, 6'd30, 5'd30, 5'd12, 1'b1);
        do_issue(64'd9, 64'd9, 64'd81, 6'd31, 5'd31, 5'd13, 1'b1);
        do_issue(64'd4, 64'd4, 64'd16, 6'd32, 5'd0, 5'd14, 1'b0);
        do_issue(64'd5, 64'd5, 64'd25, 6'd33, 5'd1, 5'd15, 1'b0);
        step();
        step();
        chk("rb_pre_done", 64'(done), 64'd1);
        chk("rb_pre_rob0", 64'(ROB_idx), 64'd0);
        rollback_en = 1'b1; ROB_rollback_idx = 5'd31; diff_ROB = 5'd3;
        #1;
        chk("rb_done_gated", 64'(done), 64'd0);
        chk("rb_result_zero", result, 64'd0);
        step();
        rollback_en = 1'b0;
        #1;
        chk("rb_after_done", 64'(done), 64'd0);
        wait_drain();

        // Asynchronous reset mid-operation with a full pipe.
        CDB_valid = 1'b0;
        do_issue(64'd1, 64'd1, 64'd1, 6'd40, 5'd13, 5'd16, 1'b1);
        do_issue(64'd2, 64'd2, 64'd4, 6'd41, 5'd14, 5'd17, 1'b1);
        do_issue(64'd3, 64'd3, 64'd9, 6'd42, 5'd15, 5'd18, 1'b1);
        do_issue(64'd4, 64'd4, 64'd16, 6'd43, 5'd16, 5'd19, 1'b1);
        chk("mr_pre_done", 64'(done), 64'd1);
        chk("mr_pre_result", result, 64'd1);
        reset = 1'b0;
        #1;
        chk("mr_done_async", 64'(done), 64'd0);
        chk("mr_result_async", result, 64'd0);
        #1;
        reset = 1'b1;
        exp_q.delete();
        step();
        CDB_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("mr_empty_done", 64'(done), 64'd0);
            step();
        end
        chk("mr_ready", 64'(ready), 64'd1);

        // en=0 freeze with a full pipe and a free CDB slot.
        CDB_valid = 1'b0;
        do_issue(64'd10, 64'd10, 64'd100, 6'd50, 5'd20, 5'd20, 1'b1);
        do_issue(64'h100, 64'h100, 64'h10000, 6'd51, 5'd21, 5'd21, 1'b1);
        do_issue(64'hDEAD, 64'd1, 64'hDEAD, 6'd52, 5'd22, 5'd22, 1'b1);
        do_issue(64'h1_0000_0000, 64'h1_0000_0001, 64'h1_0000_0000, 6'd53, 5'd23, 5'd23, 1'b1);
        en = 1'b0;
        CDB_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_ready", 64'(ready), 64'd0);
            chk("frz_done", 64'(done), 64'd1);
            chk("frz_result", result, 64'd100);
            chk("frz_ROB_idx", 64'(ROB_idx), 64'd20);
            step();
        end
        chk("frz_queue_intact", 64'(exp_q.size()), 64'd4);
        en = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded want finish");
        $fatal(1);
    end

endmodule
